// File: rtl/vec_sel_pkg.sv
// Shared definitions for the vector-slice scheduler: default geometry,
// FSM encoding and a slice-extract helper.
package vec_sel_pkg;
    localparam int WIDTH = 1024;
    localparam int BIT   = 32;
    localparam int NUM   = WIDTH / BIT;
    localparam int IDX_W = $clog2(NUM);
    localparam int NREQ  = 4;
    localparam int LEN_W = 6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [BIT-1:0] slice_of(input logic [WIDTH-1:0] v,
                                                input logic [IDX_W-1:0] k);
        return v[k*BIT +: BIT];
    endfunction
endpackage

// File: rtl/vec_sel_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after rr_ptr,
// searching cyclically upward.
module vec_sel_rr_pick #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [ID_W-1:0] win_id
);
    always_comb begin
        logic found;
        int   k;
        found  = 1'b0;
        k      = 0;
        win_oh = '0;
        win_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = (int'(rr_ptr) + i) % NREQ;
            if (!found && req[k]) begin
                found     = 1'b1;
                win_oh[k] = 1'b1;
                win_id    = ID_W'(k);
            end
        end
    end
endmodule

// File: rtl/vec_sel_sched.sv
// Round-robin burst scheduler streaming BIT-wide slices of vec_in.
// Optional VEC_SEL_SCHED_HOLD_EN adds out_ready backpressure.
module vec_sel_sched
    import vec_sel_pkg::*;
#(
    parameter int WIDTH = vec_sel_pkg::WIDTH,
    parameter int BIT   = vec_sel_pkg::BIT,
    parameter int NUM   = WIDTH / BIT,
    parameter int IDX_W = $clog2(NUM),
    parameter int NREQ  = vec_sel_pkg::NREQ,
    parameter int ID_W  = $clog2(NREQ),
    parameter int LEN_W = vec_sel_pkg::LEN_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*IDX_W-1:0] req_start,
    input  logic [NREQ*LEN_W-1:0] req_len,
    input  logic [WIDTH-1:0]      vec_in,
`ifdef VEC_SEL_SCHED_HOLD_EN
    input  logic                  out_ready,
`endif
    output logic [NREQ-1:0]       gnt,
    output logic                  out_valid,
    output logic [BIT-1:0]        out_data,
    output logic [ID_W-1:0]       out_id,
    output logic                  out_last,
    output logic                  busy
);
    state_t           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  owner;
    logic [IDX_W-1:0] idx;
    logic [LEN_W-1:0] cnt;
    logic [NREQ-1:0]  win_oh;
    logic [ID_W-1:0]  win_id;
    logic [IDX_W-1:0] win_start;
    logic [LEN_W-1:0] win_len;
    logic             adv;

    vec_sel_rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .win_oh (win_oh),
        .win_id (win_id)
    );

    assign win_start = req_start[win_id*IDX_W +: IDX_W];
    assign win_len   = req_len[win_id*LEN_W +: LEN_W];

`ifdef VEC_SEL_SCHED_HOLD_EN
    assign adv = !out_valid || out_ready;
`else
    assign adv = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            idx       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    if (|req) begin
                        gnt    <= win_oh;
                        rr_ptr <= (int'(win_id) == NREQ-1) ? '0 : win_id + 1'b1;
                        idx    <= win_start;
                        cnt    <= win_len;
                        owner  <= win_id;
                        // A zero-length burst is accepted but never leaves IDLE.
                        if (win_len != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (adv) begin
`ifdef VEC_SEL_SCHED_HOLD_EN
                        // All beats loaded: leave only once the final one is taken.
                        if (cnt == '0) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            out_valid <= 1'b1;
                            out_data  <= vec_in[idx*BIT +: BIT];
                            out_id    <= owner;
                            out_last  <= (cnt == LEN_W'(1));
                            idx       <= idx + 1'b1;
                            cnt       <= cnt - 1'b1;
                        end
`else
                        out_valid <= 1'b1;
                        out_data  <= vec_in[idx*BIT +: BIT];
                        out_id    <= owner;
                        out_last  <= (cnt == LEN_W'(1));
                        idx       <= idx + 1'b1;
                        cnt       <= cnt - 1'b1;
                        if (cnt == LEN_W'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_sel_sched.sv
// Directed bench for vec_sel_sched; slice k of vec_in holds k+100.
module tb_vec_sel_sched;
    localparam int WIDTH = 1024;
    localparam int BIT   = 32;
    localparam int IDX_W = 5;
    localparam int NREQ  = 4;
    localparam int ID_W  = 2;
    localparam int LEN_W = 6;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*IDX_W-1:0] req_start = '0;
    logic [NREQ*LEN_W-1:0] req_len = '0;
    logic [WIDTH-1:0]      vec_in;
    logic [NREQ-1:0]       gnt;
    logic                  out_valid;
    logic [BIT-1:0]        out_data;
    logic [ID_W-1:0]       out_id;
    logic                  out_last;
    logic                  busy;
`ifdef VEC_SEL_SCHED_HOLD_EN
    logic                  out_ready = 1'b1;
`endif

    int tests = 0;
    int fails = 0;

    vec_sel_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_start (req_start),
        .req_len   (req_len),
        .vec_in    (vec_in),
`ifdef VEC_SEL_SCHED_HOLD_EN
        .out_ready (out_ready),
`endif
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input int start, input int len);
        req_start[r*IDX_W +: IDX_W] = IDX_W'(start);
        req_len[r*LEN_W +: LEN_W]   = LEN_W'(len);
    endtask

    task automatic chk_beat(input string tag, input int data, input int id, input logic last);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".data"},  64'(out_data),  64'(data));
        chk({tag, ".id"},    64'(out_id),    64'(id));
        chk({tag, ".last"},  64'(out_last),  64'(last));
    endtask

    initial begin
        for (int k = 0; k < WIDTH/BIT; k++) vec_in[k*BIT +: BIT] = BIT'(k + 100);

        // Reset state
        tick(); tick();
        chk("rst.gnt", 64'(gnt), 0);
        chk("rst.valid", 64'(out_valid), 0);
        chk("rst.data", 64'(out_data), 0);
        chk("rst.last", 64'(out_last), 0);
        chk("rst.busy", 64'(busy), 0);
        rst = 1'b0;

        // Basic burst: start 3, len 4
        set_req(0, 3, 4);
        req = 4'b0001;
        tick();
        chk("b1.gnt", 64'(gnt), 64'b0001);
        chk("b1.busy", 64'(busy), 1);
        chk("b1.valid0", 64'(out_valid), 0);
        req = '0;
        tick(); chk_beat("b1.0", 103, 0, 1'b0);
        chk("b1.gnt_pulse", 64'(gnt), 0);
        tick(); chk_beat("b1.1", 104, 0, 1'b0);
        tick(); chk_beat("b1.2", 105, 0, 1'b0);
        tick(); chk_beat("b1.3", 106, 0, 1'b1);
        chk("b1.busy_fall", 64'(busy), 0);
        tick();
        chk("b1.valid_end", 64'(out_valid), 0);
        chk("b1.last_end", 64'(out_last), 0);

        // Index wrap: start 30, len 4
        set_req(2, 30, 4);
        req = 4'b0100;
        tick();
        chk("wr.gnt", 64'(gnt), 64'b0100);
        req = '0;
        tick(); chk_beat("wr.0", 130, 2, 1'b0);
        tick(); chk_beat("wr.1", 131, 2, 1'b0);
        tick(); chk_beat("wr.2", 100, 2, 1'b0);
        tick(); chk_beat("wr.3", 101, 2, 1'b1);
        tick();

        // Fairness from rr_ptr=0 with all requesters held high
        rst = 1'b1; tick(); rst = 1'b0;
        for (int r = 0; r < NREQ; r++) set_req(r, r, 1);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rr.gnt%0d", i), 64'(gnt), 64'(1 << (i % 4)));
            tick();
            if (i == 4) req = '0;
            chk($sformatf("rr.gap%0d", i), 64'(gnt), 0);
            chk_beat($sformatf("rr.beat%0d", i), 100 + (i % 4), i % 4, 1'b1);
        end
        tick();
        chk("rr.quiet", 64'(out_valid), 0);

        // Zero-length burst, then immediate follow-on grant
        set_req(1, 7, 0);
        req = 4'b0010;
        tick();
        chk("l0.gnt", 64'(gnt), 64'b0010);
        chk("l0.busy", 64'(busy), 0);
        chk("l0.valid", 64'(out_valid), 0);
        set_req(0, 5, 1);
        req = 4'b0001;
        tick();
        chk("l0.next_gnt", 64'(gnt), 64'b0001);
        chk("l0.next_busy", 64'(busy), 1);
        req = '0;
        tick(); chk_beat("l0.beat", 105, 0, 1'b1);
        tick();
        chk("l0.quiet", 64'(out_valid), 0);

        // Reset during beat 2 of an 8-beat burst (rr_ptr is 1 here)
        set_req(0, 10, 8);
        req = 4'b0001;
        tick();
        chk("mr.gnt", 64'(gnt), 64'b0001);
        req = '0;
        tick(); chk_beat("mr.0", 110, 0, 1'b0);
        tick(); chk_beat("mr.1", 111, 0, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("mr.valid", 64'(out_valid), 0);
        chk("mr.last", 64'(out_last), 0);
        chk("mr.busy", 64'(busy), 0);
        chk("mr.data", 64'(out_data), 0);
        tick();
        rst = 1'b0;
        set_req(0, 0, 0);
        set_req(3, 0, 0);
        req = 4'b1001;
        tick();
        chk("mr.gnt_after", 64'(gnt), 64'b0001);
        chk("mr.no_last", 64'(out_last), 0);
        tick();
        chk("mr.gnt_next", 64'(gnt), 64'b1000);
        req = '0;
        tick();

`ifdef VEC_SEL_SCHED_HOLD_EN
        begin
            int   got [$];
            logic pv;
            logic [BIT-1:0] pd;
            rst = 1'b1; tick(); rst = 1'b0;
            set_req(0, 0, 4);
            req = 4'b0001;
            out_ready = 1'b1;
            tick();
            chk("hd.gnt", 64'(gnt), 64'b0001);
            req = '0;
            for (int c = 0; c < 12; c++) begin
                out_ready = !(c >= 2 && c <= 4);
                #1;
                if (out_valid && out_ready) got.push_back(int'(out_data));
                pv = out_valid && !out_ready;
                pd = out_data;
                tick();
                if (pv) chk($sformatf("hd.stable%0d", c), 64'(out_data), 64'(pd));
            end
            chk("hd.count", 64'(got.size()), 4);
            for (int i = 0; i < got.size() && i < 4; i++)
                chk($sformatf("hd.beat%0d", i), 64'(got[i]), 64'(100 + i));
            chk("hd.idle", 64'(busy), 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
